// File: rtl/npu_pkg.sv
// Shared NPU definitions: default pixel width and a signed-compare helper
// that works for any operand width.
package npu_pkg;

  localparam int DATA_W_DEF = 8;

  // Decide a >= b for two's complement operands given only their sign bits
  // and the result of an unsigned compare of the full words. When the signs
  // differ, the non-negative operand is larger. When they match, the
  // unsigned order equals the signed order.
  function automatic logic signed_ge(input logic a_msb,
                                     input logic b_msb,
                                     input logic unsigned_ge);
    logic ge;
    if (a_msb != b_msb) begin
      ge = b_msb;
    end else begin
      ge = unsigned_ge;
    end
    return ge;
  endfunction

endpackage

// File: rtl/maxpool_2x2_stream_max2.sv
// Combinational signed maximum of two DATA_W-bit operands.
module max2
  import npu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic a_ge_b_s;

  // Select the larger operand; on a tie either one is the same value.
  always_comb begin
    a_ge_b_s = signed_ge(a[DATA_W-1], b[DATA_W-1], (a >= b));
    if (a_ge_b_s) begin
      y = a;
    end else begin
      y = b;
    end
  end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 max-pooling over a raster-ordered image. Pairs of pixels in
// a row are reduced horizontally; even-row results are parked in a line
// buffer and combined with the matching odd-row result to emit one pooled
// pixel per 2x2 block.
module maxpool_2x2_stream
  import npu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              en,
  output logic [DATA_W-1:0] out,
  output logic              out_en,
  output logic              frame_done
);

  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int LB_N     = IMG_W / 2;
  localparam int LB_IDX_W = (LB_N > 1) ? $clog2(LB_N) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [COL_W-1:0]    col_r;
  logic [ROW_W-1:0]    row_r;
  logic [DATA_W-1:0]   hold_r;
  logic [DATA_W-1:0]   lb_r [LB_N];

  logic                col_odd_s;
  logic                row_odd_s;
  logic                col_last_s;
  logic                row_last_s;
  logic                pool_s;
  logic [LB_IDX_W-1:0] lb_idx_s;
  logic [DATA_W-1:0]   lb_rd_s;
  logic [DATA_W-1:0]   hmax_s;
  logic [DATA_W-1:0]   vmax_s;

  assign col_odd_s  = col_r[0];
  assign row_odd_s  = row_r[0];
  assign col_last_s = (col_r == COL_LAST);
  assign row_last_s = (row_r == ROW_LAST);
  assign pool_s     = en & row_odd_s & col_odd_s;
  assign lb_idx_s   = LB_IDX_W'(col_r >> 1);
  assign lb_rd_s    = lb_r[lb_idx_s];

  max2 #(.DATA_W(DATA_W)) u_hmax (
    .a (hold_r),
    .b (in),
    .y (hmax_s)
  );

  max2 #(.DATA_W(DATA_W)) u_vmax (
    .a (lb_rd_s),
    .b (hmax_s),
    .y (vmax_s)
  );

  // Raster position: column wraps into the row, row wraps into the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (en) begin
      if (col_last_s) begin
        col_r <= {COL_W{1'b0}};
        if (row_last_s) begin
          row_r <= {ROW_W{1'b0}};
        end else begin
          row_r <= row_r + ROW_ONE;
        end
      end else begin
        col_r <= col_r + COL_ONE;
      end
    end
  end

  // Capture the left pixel of each horizontal pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r <= {DATA_W{1'b0}};
    end else if (en && !col_odd_s) begin
      hold_r <= in;
    end
  end

  // Park the even-row horizontal maxima; every entry is written before it
  // is read in the following odd row, so no reset is needed.
  always_ff @(posedge clk) begin
    if (en && !row_odd_s && col_odd_s) begin
      lb_r[lb_idx_s] <= hmax_s;
    end
  end

  // Register the pooled pixel and its one-cycle strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= {DATA_W{1'b0}};
      out_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_en     <= pool_s;
      frame_done <= pool_s & row_last_s & col_last_s;
      if (pool_s) begin
        out <= vmax_s;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Self-checking bench for maxpool_2x2_stream: a 4x2 instance for the small
// directed frames and a default-size instance for back-to-back frames.
module tb_maxpool_2x2_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_in, b_in;
  logic       a_en, b_en;
  logic [7:0] a_out, b_out;
  logic       a_oen, b_oen, a_fd, b_fd;

  always #5 clk = ~clk;

  maxpool_2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(2)) dut_a (
    .clk(clk), .reset(reset), .in(a_in), .en(a_en),
    .out(a_out), .out_en(a_oen), .frame_done(a_fd)
  );

  maxpool_2x2_stream dut_b (
    .clk(clk), .reset(reset), .in(b_in), .en(b_en),
    .out(b_out), .out_en(b_oen), .frame_done(b_fd)
  );

  typedef struct {
    logic [7:0] v;
    bit         fd;
    int         cyc;
  } pulse_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         cycle_err;
  logic [7:0] stim [$];
  pulse_t     obs_q [$];
  pulse_t     exp_q [$];
  int         pos_m [2];
  logic [7:0] last_out [2];
  logic [7:0] fr [2][10][6];

  function automatic logic [7:0] max4(input logic [7:0] p0, input logic [7:0] p1,
                                      input logic [7:0] p2, input logic [7:0] p3);
    logic signed [7:0] m;
    m = p0;
    if ($signed(p1) > m) m = p1;
    if ($signed(p2) > m) m = p2;
    if ($signed(p3) > m) m = p3;
    return m;
  endfunction

  // Stream stim[] into one instance (sel 0 = 4x2, 1 = 6x10) with 'gap' idle
  // cycles before every pixel (negative = random 0..3). Records observed and
  // model pulses and counts cycles where strobes or held output disagree.
  task automatic run_stream(input int sel, input int gap);
    int         w = sel ? 6 : 4;
    int         h = sel ? 10 : 2;
    bit         pend = 1'b0;
    bit         efd  = 1'b0;
    logic [7:0] ev = 8'h00;
    logic [7:0] o;
    logic       oen, ofd;
    obs_q.delete();
    exp_q.delete();
    cycle_err = 0;
    for (int i = 0; i <= stim.size(); i++) begin
      int g = (i == stim.size()) ? 3 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
      for (int k = 0; k <= g; k++) begin
        bit act = (k == g) && (i < stim.size());
        @(negedge clk);
        cyc++;
        o   = sel ? b_out : a_out;
        oen = sel ? b_oen : a_oen;
        ofd = sel ? b_fd  : a_fd;
        if (oen === 1'b1) obs_q.push_back('{o, ofd, cyc});
        if (pend) exp_q.push_back('{ev, efd, cyc});
        if (oen !== pend) cycle_err++;
        else if (!oen && (ofd !== 1'b0 || o !== last_out[sel])) cycle_err++;
        if (oen === 1'b1) last_out[sel] = o;
        pend = 1'b0;
        efd  = 1'b0;
        if (sel) begin
          b_en = act;
          b_in = act ? stim[i] : 8'($urandom);
        end else begin
          a_en = act;
          a_in = act ? stim[i] : 8'($urandom);
        end
        if (act) begin
          int r = pos_m[sel] / w;
          int c = pos_m[sel] % w;
          fr[sel][r][c] = stim[i];
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            pend = 1'b1;
            ev   = max4(fr[sel][r-1][c-1], fr[sel][r-1][c], fr[sel][r][c-1], fr[sel][r][c]);
            efd  = (r == h - 1) && (c == w - 1);
          end
          pos_m[sel] = (pos_m[sel] + 1) % (w * h);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_en = 1'b0; b_en = 1'b0; a_in = 8'h00; b_in = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_out, a_oen, a_fd} !== 10'd0 || {b_out, b_oen, b_fd} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: a=%h/%b/%b b=%h/%b/%b expected all zero", a_out, a_oen, a_fd, b_out, b_oen, b_fd);
    end
    reset = 1'b0;
    pos_m[0] = 0; pos_m[1] = 0;
    last_out[0] = 8'h00; last_out[1] = 8'h00;
  endtask

  task automatic test_basic();
    logic [7:0] want [2] = '{8'd5, 8'd9};
    stim = '{8'd1, 8'd5, 8'd3, 8'd2, 8'd4, 8'd0, 8'd7, 8'd9};
    run_stream(0, 0);
    n_cmp++;
    if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
      n_bad++;
      $display("FAIL basic_count: got %0d pulses expected 2 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_cmp++;
      if (obs_q[i].v !== want[i] || obs_q[i].fd !== (i == 1) || obs_q[i].cyc !== exp_q[i].cyc) begin
        n_bad++;
        $display("FAIL basic_pulse%0d: got out=%0d fd=%b cyc=%0d expected out=%0d fd=%b cyc=%0d",
                 i, obs_q[i].v, obs_q[i].fd, obs_q[i].cyc, want[i], (i == 1), exp_q[i].cyc);
      end
    end
    n_cmp++;
    if (cycle_err !== 0) begin
      n_bad++;
      $display("FAIL basic_idle_cycles: got %0d bad cycles expected 0", cycle_err);
    end
  endtask

  task automatic test_signed();
    logic [7:0] want [2] = '{8'h02, 8'h80};
    stim = '{8'hFD, 8'h80, 8'h80, 8'h80, 8'h02, 8'hFF, 8'h80, 8'h80};
    run_stream(0, 0);
    n_cmp++;
    if (obs_q.size() !== 2) begin
      n_bad++;
      $display("FAIL signed_count: got %0d pulses expected 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_cmp++;
      if (obs_q[i].v !== want[i] || obs_q[i].fd !== (i == 1)) begin
        n_bad++;
        $display("FAIL signed_pulse%0d: got out=%h fd=%b expected out=%h fd=%b",
                 i, obs_q[i].v, obs_q[i].fd, want[i], (i == 1));
      end
    end
    n_cmp++;
    if (cycle_err !== 0) begin
      n_bad++;
      $display("FAIL signed_idle_cycles: got %0d bad cycles expected 0", cycle_err);
    end
  endtask

  task automatic test_en_gaps();
    logic [7:0] want [2] = '{8'd5, 8'd9};
    stim = '{8'd1, 8'd5, 8'd3, 8'd2, 8'd4, 8'd0, 8'd7, 8'd9};
    run_stream(0, 3);
    n_cmp++;
    if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
      n_bad++;
      $display("FAIL gaps_count: got %0d pulses expected 2 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].v !== want[i] || obs_q[i].fd !== (i == 1) || obs_q[i].cyc !== exp_q[i].cyc) begin
        n_bad++;
        $display("FAIL gaps_pulse%0d: got out=%0d fd=%b cyc=%0d expected out=%0d fd=%b cyc=%0d",
                 i, obs_q[i].v, obs_q[i].fd, obs_q[i].cyc, want[i], (i == 1), exp_q[i].cyc);
      end
    end
    n_cmp++;
    if (cycle_err !== 0) begin
      n_bad++;
      $display("FAIL gaps_idle_cycles: got %0d bad cycles expected 0", cycle_err);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] want [2] = '{8'd5, 8'd9};
    stim = '{8'd90, 8'd91, 8'd92, 8'd93, 8'd94};
    run_stream(0, 0);
    n_cmp++;
    if (obs_q.size() !== 0) begin
      n_bad++;
      $display("FAIL midreset_partial: got %0d pulses expected 0", obs_q.size());
    end
    @(negedge clk);
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({a_out, a_oen, a_fd} !== 10'd0) begin
      n_bad++;
      $display("FAIL midreset_async_clear: got out=%h out_en=%b fd=%b expected zeros", a_out, a_oen, a_fd);
    end
    @(negedge clk);
    reset = 1'b0;
    pos_m[0] = 0; pos_m[1] = 0;
    last_out[0] = 8'h00; last_out[1] = 8'h00;
    stim = '{8'd1, 8'd5, 8'd3, 8'd2, 8'd4, 8'd0, 8'd7, 8'd9};
    run_stream(0, 0);
    n_cmp++;
    if (obs_q.size() !== 2) begin
      n_bad++;
      $display("FAIL midreset_count: got %0d pulses expected 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_cmp++;
      if (obs_q[i].v !== want[i] || obs_q[i].fd !== (i == 1)) begin
        n_bad++;
        $display("FAIL midreset_pulse%0d: got out=%0d fd=%b expected out=%0d fd=%b",
                 i, obs_q[i].v, obs_q[i].fd, want[i], (i == 1));
      end
    end
    n_cmp++;
    if (cycle_err !== 0) begin
      n_bad++;
      $display("FAIL midreset_idle_cycles: got %0d bad cycles expected 0", cycle_err);
    end
  endtask

  task automatic test_back_to_back();
    stim.delete();
    for (int i = 0; i < 120; i++) stim.push_back(8'(i));
    run_stream(1, 0);
    n_cmp++;
    if (obs_q.size() !== 30) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d pulses expected 30", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 30; i++) begin
      int         j   = i % 15;
      logic [7:0] val = 8'(7 + 2 * (j % 3) + 12 * (j / 3) + ((i >= 15) ? 60 : 0));
      bit         fd  = (i == 14) || (i == 29);
      n_cmp++;
      if (obs_q[i].v !== val || obs_q[i].fd !== fd ||
          (i < exp_q.size() && obs_q[i].cyc !== exp_q[i].cyc)) begin
        n_bad++;
        $display("FAIL b2b_pulse%0d: got out=%0d fd=%b cyc=%0d expected out=%0d fd=%b",
                 i, obs_q[i].v, obs_q[i].fd, obs_q[i].cyc, val, fd);
      end
    end
    n_cmp++;
    if (cycle_err !== 0) begin
      n_bad++;
      $display("FAIL b2b_idle_cycles: got %0d bad cycles expected 0", cycle_err);
    end
  endtask

  task automatic test_random();
    for (int sel = 0; sel < 2; sel++) begin
      stim.delete();
      for (int i = 0; i < (sel ? 180 : 40); i++) stim.push_back(8'($urandom));
      run_stream(sel, -1);
      n_cmp++;
      if (obs_q.size() !== exp_q.size() || obs_q.size() !== (sel ? 45 : 10)) begin
        n_bad++;
        $display("FAIL random%0d_count: got %0d pulses expected %0d", sel, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i].v !== exp_q[i].v || obs_q[i].fd !== exp_q[i].fd || obs_q[i].cyc !== exp_q[i].cyc) begin
          n_bad++;
          $display("FAIL random%0d_pulse%0d: got out=%h fd=%b cyc=%0d expected out=%h fd=%b cyc=%0d",
                   sel, i, obs_q[i].v, obs_q[i].fd, obs_q[i].cyc, exp_q[i].v, exp_q[i].fd, exp_q[i].cyc);
        end
      end
      n_cmp++;
      if (cycle_err !== 0) begin
        n_bad++;
        $display("FAIL random%0d_idle_cycles: got %0d bad cycles expected 0", sel, cycle_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_en_gaps();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
